reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Shares one W-bit storage register, built from D flip-flops, among N requesters.
- Round-robin arbitration picks one requester at a time. A 3-state FSM applies the winner's command (load / set-all / clear-all / toggle) to the register and acknowledges with a one-cycle grant.
- Sits between requesting control blocks and the shared flop bank. It is the only writer of that register.

Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, width of requester index; must equal clog2(N)
- W, 8, register width
- RESET_VAL, {W{1'b0}}, register value after reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset, sampled on rising clk
- req  input  N  per-requester level request
- cmd  input  2*N  per-requester command; requester i uses bits [2i+1:2i]
- wdata  input  N*W  per-requester load data; requester i uses bits [W*i+W-1:W*i]
- gnt  output  N  one-hot grant/ack pulse, registered
- q  output  W  shared register value, registered
- busy  output  1  high while the FSM is in EXEC or DONE
- last_id  output  IDW  index of the most recently granted requester

Behaviour:
- Reset (synchronous, highest priority, any state, including mid-transaction):
  - state=IDLE, q=RESET_VAL, gnt=0, busy=0, last_id=0, ptr=0.
  - Any in-flight command is discarded.
- Command encoding: 00 LOAD q<=wdata_i; 01 SET q<=all ones; 10 CLR q<=0; 11 TOGGLE q<=~q.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first set req bit searching ptr, ptr+1, ... with wrap modulo N.
  - Latch w, cmd_w and wdata_w into internal registers; go to EXEC.
  - Inputs are sampled only at this edge.
- EXEC (1 cycle):
  - gnt[w]=1, busy=1.
  - At the end of the cycle, q is updated per the latched command, last_id<=w, ptr<=(w+1) mod N.
  - Go to DONE.
- DONE (1 cycle):
  - gnt=0, busy=1, q holds its new value, req is ignored. Go to IDLE.
  - Requesters deassert req during DONE.
  - A req still high when IDLE samples is a new request.
- Throughput and latency:
  - One transaction per 3 cycles.
  - The request is seen at edge T; gnt is high in cycle T+1; the new q is visible from cycle T+2.
- Requester behaviour:
  - Each requester is granted at most once per round-robin sweep while others are pending.
  - A lone continuous requester is granted every 3 cycles.
- Simultaneous events:
  - Requests arriving during EXEC/DONE wait; none are lost while req is held.
  - Reset concurrent with the EXEC edge: reset wins, q=RESET_VAL.
- Out-of-range ptr (N not a power of 2): ptr wraps from N-1 to 0 and never reaches values >= N.
- gnt is always one-hot or zero. The verifier asserts $onehot0(gnt) and that gnt!=0 only in EXEC.

Decomposition:
- Shared package/header `reg_arb_defs`:
  - command codes CMD_LOAD=2'b00, CMD_SET=2'b01, CMD_CLR=2'b10, CMD_TOG=2'b11
  - state codes S_IDLE=2'b00, S_EXEC=2'b01, S_DONE=2'b10
- One sub-module `rr_pick`: a combinational round-robin selector.
  - Inputs: req[N], ptr[IDW].
  - Outputs: any, win_id[IDW].
  - It has no state; ptr is held in the parent.
- Parent contains the FSM, latches, ptr and the q register.

Test Plan (N=4, W=8, RESET_VAL=8'h00):
- Reset held 2 cycles with all req=1 -> q=8'h00, gnt=4'b0000, busy=0, last_id=0 throughout. First grant occurs only after reset falls.
- req[2]=1, cmd=LOAD, wdata=8'hA5, sampled at edge T -> gnt=4'b0100 in cycle T+1 only; q=8'hA5 and last_id=2 from T+2; busy=1 in T+1..T+2; req dropped in DONE gives no second grant.
- req=4'b1111 held continuously from ptr=0, all CLR except req[3]=SET -> grant order 0,1,2,3,0 at 3-cycle spacing; q=8'hFF after the grant to 3, then 8'h00 after the next grant to 0.
- LOAD 8'h3C by req[1], then two TOGGLEs by req[1] -> q sequence 8'h3C, 8'hC3, 8'h3C; each update lands 2 cycles after its sampling edge.
- req[0] LOAD 8'h55 with reset asserted during EXEC -> q=8'h00 next cycle, gnt=0 after the reset edge, state IDLE, ptr=0. The next req=4'b1001 grants requester 0 first.
- ptr=3 (after a grant to 2), req=4'b0011 -> requester 0 granted before 1 (wrap); then req=4'b0010 -> requester 1 granted 3 cycles later; last_id=1.

Source files
------------

// File: rtl/reg_arb_defs.sv
`default_nettype none
// ============================================================================
// Module      : reg_arb_defs (package)
// Description : Command and FSM state encodings for the shared-register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_arb_defs;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_SET  = 2'b01,
        CMD_CLR  = 2'b10,
        CMD_TOG  = 2'b11
    } cmd_e;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Stateless round-robin selector; first set req bit at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] win_id
);

    logic           w_hi_any;
    logic [IDW-1:0] w_hi_id;
    logic [IDW-1:0] w_lo_id;

    assign any = |req;

    // Lowest requester at/above ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_id  = '0;
        w_lo_id  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_lo_id = IDW'(j);
                if (IDW'(j) >= ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_id  = IDW'(j);
                end
            end
        end
        win_id = w_hi_any ? w_hi_id : w_lo_id;
    end

endmodule
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_arbiter
// Description : Round-robin arbiter granting N requesters access to one shared
//               W-bit register via a three-state IDLE/EXEC/DONE sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_access_arbiter
    import reg_arb_defs::*;
#(
    parameter int             N         = 4,
    parameter int             IDW       = 2,
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   cmd,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]     q,
    output logic             busy,
    output logic [IDW-1:0]   last_id
);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_win;
    cmd_e           r_cmd;
    logic [W-1:0]   r_wdata;
    logic [W-1:0]   r_q;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_last_id;

    logic           w_any;
    logic [IDW-1:0] w_win;
    logic           w_accept;
    logic           w_busy;
    logic [N-1:0]   w_gnt_nxt;
    logic [1:0]     w_cmd_sel;
    logic [W-1:0]   w_wdata_sel;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .win_id (w_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = (r_state == S_IDLE) && w_any;
        w_busy    = (r_state == S_EXEC) || (r_state == S_DONE);
        w_gnt_nxt = '0;
        if (w_accept) begin
            w_gnt_nxt = {{(N-1){1'b0}}, 1'b1} << w_win;
        end
    end

    // Constant-base slices keep the per-requester mux free of variable part-selects.
    always_comb begin
        w_cmd_sel   = '0;
        w_wdata_sel = '0;
        for (int j = 0; j < N; j++) begin
            if (w_win == IDW'(j)) begin
                w_cmd_sel   = cmd[2*j +: 2];
                w_wdata_sel = wdata[W*j +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= RESET_VAL;
            r_gnt     <= '0;
            r_last_id <= '0;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cmd     <= CMD_LOAD;
            r_wdata   <= '0;
        end else begin
            r_gnt <= w_gnt_nxt;
            if (w_accept) begin
                r_win   <= w_win;
                r_cmd   <= cmd_e'(w_cmd_sel);
                r_wdata <= w_wdata_sel;
            end
            if (r_state == S_EXEC) begin
                case (r_cmd)
                    CMD_LOAD: r_q <= r_wdata;
                    CMD_SET:  r_q <= '1;
                    CMD_CLR:  r_q <= '0;
                    CMD_TOG:  r_q <= ~r_q;
                endcase
                r_last_id <= r_win;
                r_ptr     <= (r_win == IDW'(N - 1)) ? '0 : r_win + IDW'(1);
            end
        end
    end

    assign gnt     = r_gnt;
    assign q       = r_q;
    assign busy    = w_busy;
    assign last_id = r_last_id;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_access_arbiter
// Description : Directed scoreboard bench for reg_access_arbiter (N=4, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_access_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = 8;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] ST  = 2'b01;
    localparam logic [1:0] CL  = 2'b10;
    localparam logic [1:0] TG  = 2'b11;

    typedef struct {
        logic [N-1:0]   gnt;
        logic [W-1:0]   q;
        logic [IDW-1:0] id;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [2*N-1:0]   cmd;
    logic [N*W-1:0]   wdata;
    logic [N-1:0]     gnt;
    logic [W-1:0]     q;
    logic             busy;
    logic [IDW-1:0]   last_id;

    exp_t       sb[$];
    exp_t       pend;
    bit         pend_valid;
    logic [W-1:0] model_q;
    int         n_vec;
    int         n_err;

    reg_access_arbiter #(
        .N         (N),
        .IDW       (IDW),
        .W         (W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .cmd     (cmd),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .busy    (busy),
        .last_id (last_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, then check invariants and consume scoreboard entries.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_valid) begin
            chk("q_after_grant", 32'(q), 32'(pend.q));
            chk("last_id", 32'(last_id), 32'(pend.id));
            pend_valid = 1'b0;
        end
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt != '0) begin
            chk("gnt_expected", 32'(sb.size() != 0), 32'd1);
            chk("busy_in_exec", 32'(busy), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("gnt_value", 32'(gnt), 32'(e.gnt));
                pend       = e;
                pend_valid = 1'b1;
            end
        end
    endtask

    task automatic drive(input int id, input logic [1:0] c, input logic [W-1:0] d);
        req[id]         = 1'b1;
        cmd[2*id +: 2]  = c;
        wdata[W*id +: W] = d;
    endtask

    task automatic push_exp(input int id);
        logic [1:0] c;
        c = cmd[2*id +: 2];
        case (c)
            LD:      model_q = wdata[W*id +: W];
            ST:      model_q = 8'hFF;
            CL:      model_q = 8'h00;
            default: model_q = ~model_q;
        endcase
        sb.push_back('{gnt: 4'(1 << id), q: model_q, id: IDW'(id)});
    endtask

    // EXEC, DONE, IDLE; requesters in drop_mask release req during DONE.
    task automatic cycle3(input logic [N-1:0] drop_mask);
        step();
        chk("gnt_latency", 32'(sb.size()), 32'd0);
        chk("busy_exec", 32'(busy), 32'd1);
        step();
        chk("busy_done", 32'(busy), 32'd1);
        chk("gnt_done", 32'(gnt), 32'd0);
        req = req & ~drop_mask;
        step();
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic txn(input int id, input logic [1:0] c, input logic [W-1:0] d);
        drive(id, c, d);
        push_exp(id);
        cycle3(4'(1 << id));
    endtask

    initial begin
        int order[5];
        n_vec      = 0;
        n_err      = 0;
        pend_valid = 1'b0;
        model_q    = 8'h00;
        reset      = 1'b1;
        req        = 4'b1111;
        cmd        = {CL, CL, CL, ST};
        wdata      = '0;

        // Reset held with all requests high: nothing may happen.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_q", 32'(q), 32'h00);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_last_id", 32'(last_id), 32'd0);
        end
        reset = 1'b0;
        push_exp(0);
        cycle3(4'b1111);

        // Lone LOAD by requester 2 (ptr=1), no regrant after drop.
        txn(2, LD, 8'hA5);
        step();
        step();

        // ptr=3: requester 0 wins over 1 by wrap, then 1 follows.
        drive(0, TG, 8'h00);
        drive(1, ST, 8'h00);
        push_exp(0);
        cycle3(4'b0001);
        push_exp(1);
        cycle3(4'b0010);

        // Reset lands on the EXEC edge: the LOAD is discarded.
        drive(0, LD, 8'h55);
        sb.push_back('{gnt: 4'b0001, q: 8'h00, id: 2'd0});
        step();
        chk("abort_gnt_seen", 32'(sb.size()), 32'd0);
        reset = 1'b1;
        req   = '0;
        step();
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset   = 1'b0;
        model_q = 8'h00;

        // ptr back at 0: requester 0 before 3.
        drive(0, LD, 8'h11);
        drive(3, LD, 8'h99);
        push_exp(0);
        cycle3(4'b0001);
        push_exp(3);
        cycle3(4'b1000);

        // All four held continuously: strict rotation at 3-cycle spacing.
        req   = 4'b1111;
        cmd   = {ST, CL, CL, CL};
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            push_exp(order[i]);
            cycle3((i == 4) ? 4'b1111 : 4'b0000);
        end

        // LOAD then two TOGGLEs by requester 1.
        txn(1, LD, 8'h3C);
        txn(1, TG, 8'h00);
        txn(1, TG, 8'h00);

        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
